// File: rtl/kip_arb_pkg.sv
// kip_arb_pkg
// Shared definitions for the KIP packet arbiter:
//   - arb_state_t      : arbiter FSM states (IDLE, BUSY)
//   - KIP_ARB_MIN_PORTS / KIP_ARB_MAX_PORTS : legal range of NUM_PORTS
//   - KIP_ARB_IDX_W    : width of the port index carried by the search helper
//   - rr_first_from()  : round-robin "first requester at or after the pointer" search
package kip_arb_pkg;

  localparam int unsigned KIP_ARB_MIN_PORTS = 2;
  localparam int unsigned KIP_ARB_MAX_PORTS = 16;
  localparam int unsigned KIP_ARB_IDX_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Scans req upward starting at ptr, wrapping at num_ports, and returns the
  // first asserted index. ptr is always below num_ports, so a candidate never
  // exceeds 2*num_ports-2 and a single subtraction performs the wrap.
  // Returns 0 when nothing is requesting; callers only use the result when
  // at least one request is present.
  function automatic logic [KIP_ARB_IDX_W-1:0] rr_first_from(
    input logic [KIP_ARB_MAX_PORTS-1:0] req,
    input logic [KIP_ARB_IDX_W-1:0]     ptr,
    input int unsigned                  num_ports
  );
    logic [KIP_ARB_IDX_W-1:0] pick;
    logic                     found;
    int unsigned              cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < KIP_ARB_MAX_PORTS; i++) begin
      cand = {{(32-KIP_ARB_IDX_W){1'b0}}, ptr} + i;
      if (cand >= num_ports) begin
        cand = cand - num_ports;
      end
      if ((i < num_ports) && !found && req[cand[KIP_ARB_IDX_W-1:0]]) begin
        pick  = cand[KIP_ARB_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/kip_axis_skid.sv
// kip_axis_skid
// Two-entry AXI-Stream register slice. The payload is an opaque bus. Every
// output, including in_ready, comes straight from a flop, so no combinational
// path crosses the slice in either direction, and one beat per cycle is
// sustained.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (empties the slice)
//   in_valid/in_ready   : upstream handshake
//   in_data [WIDTH]     : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_data [WIDTH]    : downstream payload
module kip_axis_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] skid_data;

  // The output register holds the head beat. The skid register catches the
  // beat that arrives in the same cycle the downstream stalls. in_ready is low
  // exactly when the skid register is occupied. While the skid register is
  // full, the output register is necessarily valid too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else if (in_ready) begin
      if (in_valid) begin
        if (!out_valid || out_ready) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          skid_data <= in_data;
          in_ready  <= 1'b0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (out_ready) begin
      out_data <= skid_data;
      in_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/kip_arbiter.sv
// kip_arbiter
// Packet-level round-robin arbiter. It merges NUM_PORTS kernel AXI-Stream
// sources onto one KIP stream. A grant is held from the first beat of a packet
// until its tlast beat is accepted, so packets never interleave. tdata, tkeep,
// tuser and tlast pass through unmodified.
// Optional feature macro: KIP_ARB_OUTPUT_REG_EN
//   When defined, a two-entry skid buffer (kip_axis_skid) registers the master
//   side. Packet release then uses acceptance into that buffer.
// Ports:
//   i_clk, i_ap_rst_n   : clock, asynchronous active-low reset
//   s_tvalid/s_tready   : per-port handshake [NUM_PORTS]
//   s_tdata/tkeep/tuser : per-port payload, port p at slice [p*W +: W]
//   s_tlast             : per-port last [NUM_PORTS]
//   m_*                 : merged master stream toward the KIP router
//   o_grant             : one-hot current grant, zero while idle
//   o_busy              : high while a packet is in flight
module kip_arbiter
  import kip_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned AXIS_DATA_WIDTH      = 512,
  parameter int unsigned AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_KIP_TUSER_WIDTH = 32
) (
  input  logic                                      i_clk,
  input  logic                                      i_ap_rst_n,
  input  logic [NUM_PORTS-1:0]                      s_tvalid,
  output logic [NUM_PORTS-1:0]                      s_tready,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]      s_tdata,
  input  logic [NUM_PORTS*AXIS_KEEP_WIDTH-1:0]      s_tkeep,
  input  logic [NUM_PORTS*AXIS_KIP_TUSER_WIDTH-1:0] s_tuser,
  input  logic [NUM_PORTS-1:0]                      s_tlast,
  output logic                                      m_tvalid,
  input  logic                                      m_tready,
  output logic [AXIS_DATA_WIDTH-1:0]                m_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]                m_tkeep,
  output logic [AXIS_KIP_TUSER_WIDTH-1:0]           m_tuser,
  output logic                                      m_tlast,
  output logic [NUM_PORTS-1:0]                      o_grant,
  output logic                                      o_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  if ((NUM_PORTS < KIP_ARB_MIN_PORTS) || (NUM_PORTS > KIP_ARB_MAX_PORTS)) begin : g_bad_num_ports
    $error("kip_arbiter: NUM_PORTS must be between 2 and 16");
  end

  arb_state_t                      state;
  logic [IDX_W-1:0]                grant_idx;
  logic [IDX_W-1:0]                rr_ptr;
  logic [IDX_W-1:0]                pick;
  logic [KIP_ARB_IDX_W-1:0]        pick_raw;
  logic [NUM_PORTS-1:0]            pick_onehot;
  logic                            sel_valid;
  logic [AXIS_DATA_WIDTH-1:0]      sel_data;
  logic [AXIS_KEEP_WIDTH-1:0]      sel_keep;
  logic [AXIS_KIP_TUSER_WIDTH-1:0] sel_user;
  logic                            sel_last;
  logic                            up_ready;
  logic                            release_pkt;

  // Winner of the next arbitration round, scanning upward from rr_ptr.
  always_comb begin
    pick_raw    = rr_first_from(16'(s_tvalid), 4'(rr_ptr), NUM_PORTS);
    pick        = IDX_W'(pick_raw);
    pick_onehot = '0;
    pick_onehot[pick] = 1'b1;
  end

  // Grant mux: selects the granted port's slice. The valid is gated by o_busy,
  // so nothing leaks through while idle.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_last  = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == IDX_W'(p)) begin
        sel_valid = o_busy & s_tvalid[p];
        sel_data  = s_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_keep  = s_tkeep[p*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        sel_user  = s_tuser[p*AXIS_KIP_TUSER_WIDTH +: AXIS_KIP_TUSER_WIDTH];
        sel_last  = s_tlast[p];
      end
    end
  end

  // Only the granted port sees ready. Every other port stalls.
  always_comb begin
    s_tready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      s_tready[p] = o_busy & (grant_idx == IDX_W'(p)) & up_ready;
    end
  end

  // A packet ends when its tlast beat leaves the grant mux.
  assign release_pkt = sel_valid & up_ready & sel_last;

`ifdef KIP_ARB_OUTPUT_REG_EN
  localparam int unsigned PAY_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + AXIS_KIP_TUSER_WIDTH + 1;

  logic [PAY_W-1:0] skid_out;

  kip_axis_skid #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk      (i_clk),
    .rst_n    (i_ap_rst_n),
    .in_valid (sel_valid),
    .in_ready (up_ready),
    .in_data  ({sel_last, sel_user, sel_keep, sel_data}),
    .out_valid(m_tvalid),
    .out_ready(m_tready),
    .out_data (skid_out)
  );

  assign {m_tlast, m_tuser, m_tkeep, m_tdata} = skid_out;
`else
  assign up_ready = m_tready;
  assign m_tvalid = sel_valid;
  assign m_tdata  = sel_data;
  assign m_tkeep  = sel_keep;
  assign m_tuser  = sel_user;
  assign m_tlast  = sel_last;
`endif

  // Arbiter FSM. In IDLE it latches the round-robin winner. In BUSY it holds
  // that grant until the tlast beat is accepted, then moves the pointer past
  // the finished port. A request that arrives on the release cycle waits for
  // the following IDLE cycle, which is the per-packet bubble.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      o_grant   <= '0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_tvalid) begin
            state     <= BUSY;
            grant_idx <= pick;
            o_grant   <= pick_onehot;
            o_busy    <= 1'b1;
          end
        end
        BUSY: begin
          if (release_pkt) begin
            state   <= IDLE;
            o_grant <= '0;
            o_busy  <= 1'b0;
            rr_ptr  <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kip_arbiter.sv
// tb_kip_arbiter
// Randomized bench for kip_arbiter in its default build (combinational master
// path). Each port's source plays packets from a queue. A packet-level
// reference model predicts grants, readiness and the merged beat stream from
// the round-robin rules.
module tb_kip_arbiter;

  localparam int NP = 4;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 32;

  logic            i_clk = 1'b0;
  logic            i_ap_rst_n;
  logic [NP-1:0]   s_tvalid;
  logic [NP-1:0]   s_tready;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP*UW-1:0] s_tuser;
  logic [NP-1:0]   s_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic            m_tlast;
  logic [NP-1:0]   o_grant;
  logic            o_busy;

  always #5 i_clk = ~i_clk;

  kip_arbiter #(
    .NUM_PORTS(NP),
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .AXIS_KIP_TUSER_WIDTH(UW)
  ) dut (
    .i_clk(i_clk),
    .i_ap_rst_n(i_ap_rst_n),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata(s_tdata),
    .s_tkeep(s_tkeep),
    .s_tuser(s_tuser),
    .s_tlast(s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata(m_tdata),
    .m_tkeep(m_tkeep),
    .m_tuser(m_tuser),
    .m_tlast(m_tlast),
    .o_grant(o_grant),
    .o_busy(o_busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t src_q[NP][$];
  beat_t mdl_q[NP][$];
  logic [NP-1:0] fire;
  int vprob;
  int rprob;
  bit mdl_busy;
  int mdl_port;
  int mdl_ptr;
  int mdl_beat;
  int checks;
  int passes;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Queues one packet of len beats on port p, for both the source and the model.
  task automatic addPacket(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
      for (int w = 0; w < KW/32; w++) b.keep[w*32 +: 32] = $urandom;
      b.user = $urandom;
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
  endtask

  // Drives sources just after the clock edge. A valid beat that was not
  // accepted is held. Otherwise valid is drawn at random.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fire[p]) src_q[p].delete(0);
      if (src_q[p].size() == 0) s_tvalid[p] = 1'b0;
      else if (!(s_tvalid[p] && !fire[p])) s_tvalid[p] = (int'($urandom_range(99)) < vprob);
      if (src_q[p].size() != 0) begin
        s_tdata[p*DW +: DW] = src_q[p][0].data;
        s_tkeep[p*KW +: KW] = src_q[p][0].keep;
        s_tuser[p*UW +: UW] = src_q[p][0].user;
        s_tlast[p]          = src_q[p][0].last;
      end
    end
    m_tready = (int'($urandom_range(99)) < rprob);
  endtask

  // Compares the DUT with the model at mid-cycle, then advances the model by
  // the upcoming clock edge.
  task automatic checkCycle();
    logic [NP-1:0] exp_grant;
    bit found;
    int c;
    @(negedge i_clk);
    if (!mdl_busy) begin
      checkOutput("idle_m_tvalid", m_tvalid, 0);
      checkOutput("idle_grant", o_grant, 0);
      checkOutput("idle_busy", o_busy, 0);
      checkOutput("idle_s_tready", s_tready, 0);
      if (|s_tvalid) begin
        found = 0;
        for (int k = 0; k < NP; k++) begin
          c = (mdl_ptr + k) % NP;
          if (!found && s_tvalid[c]) begin
            mdl_port = c;
            found = 1;
          end
        end
        mdl_busy = 1;
        mdl_beat = 0;
      end
    end else begin
      exp_grant = '0;
      exp_grant[mdl_port] = 1'b1;
      checkOutput("grant", o_grant, exp_grant);
      checkOutput("busy", o_busy, 1);
      checkOutput("s_tready", s_tready, m_tready ? exp_grant : '0);
      checkOutput("m_tvalid", m_tvalid, s_tvalid[mdl_port]);
      if (s_tvalid[mdl_port]) begin
        checkOutput("m_tdata", m_tdata, mdl_q[mdl_port][0].data);
        checkOutput("m_tkeep", m_tkeep, mdl_q[mdl_port][0].keep);
        checkOutput("m_tuser", m_tuser, mdl_q[mdl_port][0].user);
        checkOutput("m_tlast", m_tlast, mdl_q[mdl_port][0].last);
        if (m_tready) begin
          mdl_beat++;
          if (mdl_q[mdl_port][0].last) begin
            mdl_busy = 0;
            mdl_ptr  = (mdl_port + 1) % NP;
          end
          mdl_q[mdl_port].delete(0);
        end
      end
    end
    fire = s_tvalid & s_tready;
  endtask

  function automatic bit allEmpty();
    bit e = 1;
    for (int p = 0; p < NP; p++)
      if (src_q[p].size() != 0 || mdl_q[p].size() != 0) e = 0;
    return e;
  endfunction

  task automatic runUntilDrained(input int budget);
    int n = 0;
    while ((!allEmpty() || mdl_busy) && n < budget) begin
      applyStimulus();
      checkCycle();
      n++;
    end
    checkOutput("drained", {31'd0, (allEmpty() && !mdl_busy)}, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_m_tvalid"}, m_tvalid, 0);
    checkOutput({tag, "_grant"}, o_grant, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_s_tready"}, s_tready, 0);
  endtask

  initial begin
    int n;
    checks = 0; passes = 0;
    mdl_busy = 0; mdl_port = 0; mdl_ptr = 0; mdl_beat = 0;
    fire = '0; s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0;
    m_tready = 1'b0;
    i_ap_rst_n = 1'b1;
    #1 i_ap_rst_n = 1'b0;
    #1 checkResetOutputs("reset");
    @(posedge i_clk); @(posedge i_clk);
    #2 i_ap_rst_n = 1'b1;

    // Single 3-beat packet from port 1 with an always-ready sink.
    vprob = 100; rprob = 100;
    addPacket(1, 3);
    runUntilDrained(50);

    // Fairness: every port streams 2-beat packets back to back.
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) addPacket(p, 2);
    runUntilDrained(200);

    // Backpressure on a 4-beat packet from port 2.
    vprob = 100; rprob = 50;
    addPacket(2, 4);
    runUntilDrained(100);

    // Pointer wrap: port 2 finishes, which moves the pointer to 3. Then
    // ports 0 and 3 send single-beat packets together.
    rprob = 100;
    addPacket(2, 1);
    runUntilDrained(20);
    addPacket(0, 1);
    addPacket(3, 1);
    runUntilDrained(20);

    // Random traffic.
    vprob = 70; rprob = 60;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 6; k++) addPacket($urandom_range(NP-1), $urandom_range(5, 1));
      runUntilDrained(2000);
    end

    // Reset in the middle of a 5-beat packet, on its second beat.
    vprob = 100; rprob = 100;
    for (int p = 0; p < NP; p++) addPacket(p, 5);
    n = 0;
    while (!(mdl_busy && mdl_beat == 1) && n < 100) begin
      applyStimulus();
      checkCycle();
      n++;
    end
    checkOutput("reached_beat2", {31'd0, (mdl_busy && mdl_beat == 1)}, 1);
    applyStimulus();
    #2 i_ap_rst_n = 1'b0;
    #1 checkResetOutputs("midreset");
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
    end
    s_tvalid = '0;
    fire = '0;
    mdl_busy = 0; mdl_ptr = 0; mdl_beat = 0;
    @(posedge i_clk); @(posedge i_clk);
    for (int p = 0; p < NP; p++) addPacket(p, 2);
    #2 i_ap_rst_n = 1'b1;
    runUntilDrained(200);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
